ltc2387_adc_model: RTL and testbench

Parametrised single-clock behavioural model of an LTC2387-style ADC serial output, used to exercise the LVDS capture logic in simulation. On each CNV rising edge it latches a sample from a selectable source (loadable pattern RAM, ramp, fixed test pattern), waits a conversion latency, then shifts the word out MSB-first on one or two lanes with a centre-aligned DCO. Sits in the testbench in place of the real converter, driving the capture block under test.

---
 rtl/ltc2387_pkg.sv | 23 ++
 rtl/ltc2387_pattern_src.sv | 56 +++++
 rtl/ltc2387_adc_model.sv | 163 ++++++++++++++++
 tb/tb_ltc2387_adc_model.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ltc2387_pkg.sv
// Shared constants for the LTC2387-style ADC output model: FSM state codes,
// sample-source modes, the default test word and lane geometry helpers.
package ltc2387_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam logic [1:0] MODE_RAM   = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_PAT   = 2'd2;

    localparam logic [17:0] DEFAULT_TEST_PATTERN = 18'h28FFC;

    function automatic int bits_per_lane(input int width, input int lanes);
        return width / lanes;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ltc2387_pattern_src.sv
// Sample source for the ADC model: pattern RAM, free-running ramp or a fixed
// test word. Only the source selected by mode moves on an advance strobe.
module ltc2387_pattern_src import ltc2387_pkg::*; #(
    parameter int                   ADC_WIDTH    = 18,
    parameter int                   NUM_SAMPLES  = 16,
    parameter logic [ADC_WIDTH-1:0] TEST_PATTERN = ADC_WIDTH'(DEFAULT_TEST_PATTERN)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           mode,
    input  logic                                 advance,
    input  logic                                 wr_en,
    input  logic [addr_width(NUM_SAMPLES)-1:0]   wr_addr,
    input  logic [ADC_WIDTH-1:0]                 wr_data,
    output logic [ADC_WIDTH-1:0]                 word
);

    localparam int            AW       = addr_width(NUM_SAMPLES);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SAMPLES - 1);

    logic [ADC_WIDTH-1:0] mem_r [NUM_SAMPLES];
    logic [AW-1:0]        index_r;
    logic [ADC_WIDTH-1:0] ramp_r;

    // Pattern RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // RAM index and ramp advance only when their own source is selected
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_r <= {AW{1'b0}};
            ramp_r  <= {ADC_WIDTH{1'b0}};
        end else if (advance) begin
            case (mode)
                MODE_RAM:  index_r <= (index_r == LAST_IDX) ? {AW{1'b0}} : index_r + AW'(1'b1);
                MODE_RAMP: ramp_r  <= ramp_r + ADC_WIDTH'(1'b1);
                default:   index_r <= index_r;
            endcase
        end
    end

    // Source mux; a same-cycle RAM write is not yet visible here, so old data is latched
    always_comb begin
        word = TEST_PATTERN;
        case (mode)
            MODE_RAM:  word = mem_r[index_r];
            MODE_RAMP: word = ramp_r;
            default:   word = TEST_PATTERN;
        endcase
    end

endmodule

// File: rtl/ltc2387_adc_model.sv
// Behavioural LTC2387-style ADC serial output: CNV edge latches a sample,
// CONVERT latency, then MSB-first bursts on one or two lanes with centred DCO.
module ltc2387_adc_model import ltc2387_pkg::*; #(
    parameter int                   ADC_WIDTH    = 18,
    parameter int                   LANES        = 2,
    parameter int                   NUM_SAMPLES  = 16,
    parameter int                   CONV_CYCLES  = 4,
    parameter logic [ADC_WIDTH-1:0] TEST_PATTERN = ADC_WIDTH'(DEFAULT_TEST_PATTERN)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cnv,
    input  logic [1:0]                         mode,
    input  logic                               wr_en,
    input  logic [addr_width(NUM_SAMPLES)-1:0] wr_addr,
    input  logic [ADC_WIDTH-1:0]               wr_data,
    output logic                               dco,
    output logic                               da,
    output logic                               db,
    output logic                               busy,
    output logic                               overrun,
    output logic [ADC_WIDTH-1:0]               sample_out,
    output logic                               sample_valid
);

    localparam int BPL        = bits_per_lane(ADC_WIDTH, LANES);
    localparam int OUT_CYCLES = 2 * BPL;
    localparam int CNT_MAX    = (OUT_CYCLES > CONV_CYCLES) ? OUT_CYCLES : CONV_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'((CONV_CYCLES > 0) ? CONV_CYCLES - 1 : 0);

    if ((LANES != 1 && LANES != 2) || (ADC_WIDTH % LANES) != 0 || NUM_SAMPLES < 1) begin : g_bad_params
        $error("ltc2387_adc_model: ADC_WIDTH must divide by LANES (1 or 2), NUM_SAMPLES >= 1");
    end

    logic                 cnv_q_r;
    logic [1:0]           state_r;
    logic [CW-1:0]        cnt_r;
    logic [ADC_WIDTH-1:0] shift_r;
    logic [1:0]           state_nx_s;
    logic [CW-1:0]        cnt_nx_s;
    logic                 cnv_edge_s;
    logic                 accept_s;
    logic                 first_s;
    logic [ADC_WIDTH-1:0] src_word_s;
    logic [ADC_WIDTH-1:0] cur_word_s;
    logic [BPL-1:0]       lane_a_s;
    logic [BPL-1:0]       lane_b_s;
    logic [BPL-1:0]       win_a_s;
    logic [BPL-1:0]       win_b_s;

    assign cnv_edge_s = cnv & ~cnv_q_r;
    assign accept_s   = cnv_edge_s && (state_r == ST_IDLE);

    ltc2387_pattern_src #(
        .ADC_WIDTH    (ADC_WIDTH),
        .NUM_SAMPLES  (NUM_SAMPLES),
        .TEST_PATTERN (TEST_PATTERN)
    ) u_src (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .advance (accept_s),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .word    (src_word_s)
    );

    // Next-state and phase counter; CONV_CYCLES=0 skips CONVERT entirely
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = {CW{1'b0}};
                if (accept_s) begin
                    state_nx_s = (CONV_CYCLES == 0) ? ST_OUTPUT : ST_CONVERT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (cnt_r == CONV_LAST) begin
                    state_nx_s = ST_OUTPUT;
                    cnt_nx_s   = {CW{1'b0}};
                end else begin
                    cnt_nx_s   = cnt_r + CW'(1'b1);
                end
            end
            ST_OUTPUT: begin
                if (cnt_r == OUT_LAST) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                end else begin
                    cnt_nx_s   = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
    end

    // With zero latency the first output cycle needs the word being latched right now
    assign cur_word_s = (state_r == ST_IDLE) ? src_word_s : shift_r;
    assign first_s    = (state_nx_s == ST_OUTPUT) && (cnt_nx_s == {CW{1'b0}});

    for (genvar k = 0; k < BPL; k++) begin : g_lane
        assign lane_a_s[BPL-1-k] = cur_word_s[ADC_WIDTH-1-LANES*k];
        if (LANES == 2) begin : g_two
            assign lane_b_s[BPL-1-k] = cur_word_s[ADC_WIDTH-2-2*k];
        end else begin : g_one
            assign lane_b_s[BPL-1-k] = 1'b0;
        end
    end

    // Window k spans phase cycles 2k and 2k+1
    assign win_a_s = lane_a_s << cnt_nx_s[CW-1:1];
    assign win_b_s = lane_b_s << cnt_nx_s[CW-1:1];

    // State plus registered outputs; dco toggles entering each odd phase cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnv_q_r      <= 1'b0;
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            shift_r      <= {ADC_WIDTH{1'b0}};
            busy         <= 1'b0;
            overrun      <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= {ADC_WIDTH{1'b0}};
            dco          <= 1'b0;
            da           <= 1'b0;
            db           <= 1'b0;
        end else begin
            cnv_q_r      <= cnv;
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            busy         <= (state_nx_s != ST_IDLE);
            overrun      <= cnv_edge_s && (state_r != ST_IDLE);
            sample_valid <= first_s;
            if (accept_s) begin
                shift_r <= src_word_s;
            end
            if (first_s) begin
                sample_out <= cur_word_s;
            end
            if (state_nx_s == ST_OUTPUT) begin
                dco <= cnt_nx_s[1] ^ cnt_nx_s[0];
                da  <= win_a_s[BPL-1];
                db  <= win_b_s[BPL-1];
            end else begin
                dco <= 1'b0;
                da  <= 1'b0;
                db  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ltc2387_adc_model.sv
// Directed scoreboard bench: an 18-bit dual-lane model and a 4-bit single-lane,
// zero-latency model share one reset; bursts are checked bit by bit.
module tb_ltc2387_adc_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cnv_a, cnv_b;
    logic [1:0]  mode_a;
    logic        wr_en_a;
    logic [0:0]  wr_addr_a;
    logic [17:0] wr_data_a;

    logic        dco_a, da_a, db_a, busy_a, ov_a, sv_a;
    logic [17:0] so_a;
    logic        dco_b, da_b, db_b, busy_b, ov_b, sv_b;
    logic [3:0]  so_b;

    logic        sel;
    logic        o_dco, o_da, o_db, o_busy, o_ov, o_sv;
    logic [17:0] o_so;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] sb[$];

    ltc2387_adc_model #(
        .ADC_WIDTH(18), .LANES(2), .NUM_SAMPLES(2), .CONV_CYCLES(4)
    ) dut_a (
        .clk(clk), .reset(reset), .cnv(cnv_a), .mode(mode_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .dco(dco_a), .da(da_a), .db(db_a), .busy(busy_a), .overrun(ov_a),
        .sample_out(so_a), .sample_valid(sv_a)
    );

    ltc2387_adc_model #(
        .ADC_WIDTH(4), .LANES(1), .NUM_SAMPLES(1), .CONV_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .cnv(cnv_b), .mode(2'd1),
        .wr_en(1'b0), .wr_addr(1'b0), .wr_data(4'd0),
        .dco(dco_b), .da(da_b), .db(db_b), .busy(busy_b), .overrun(ov_b),
        .sample_out(so_b), .sample_valid(sv_b)
    );

    assign o_dco  = sel ? dco_b  : dco_a;
    assign o_da   = sel ? da_b   : da_a;
    assign o_db   = sel ? db_b   : db_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_ov   = sel ? ov_b   : ov_a;
    assign o_sv   = sel ? sv_b   : sv_a;
    assign o_so   = sel ? {14'd0, so_b} : so_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst on the selected model; optional overrun edge, reset abort, same-cycle RAM write.
    task automatic run_burst(input logic [17:0] w, input int ov_at, input int rst_at,
                             input logic do_wr, input logic [17:0] wr_d);
        int wd, lanes, cv, n, k;
        logic [17:0] cur;
        logic e_da, e_db, e_dco;
        wd    = sel ? 4 : 18;
        lanes = sel ? 1 : 2;
        cv    = sel ? 0 : 4;
        n     = 2 * wd / lanes;
        cur   = 18'd0;
        @(negedge clk);
        if (sel) cnv_b = 1'b1; else cnv_a = 1'b1;
        if (do_wr) begin
            wr_en_a = 1'b1; wr_addr_a = 1'b0; wr_data_a = wr_d;
        end
        sb.push_back(w);
        @(negedge clk);
        cnv_a = 1'b0; cnv_b = 1'b0; wr_en_a = 1'b0;
        for (int i = 0; i < cv; i++) begin
            chk("conv_busy", o_busy, 1);
            chk("conv_da", o_da, 0);
            chk("conv_sv", o_sv, 0);
            @(negedge clk);
        end
        for (int c = 0; c < n; c++) begin
            if (c == 0) begin
                chk("sv_first", o_sv, 1);
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) cur = sb.pop_front();
                chk("sample_out", o_so, cur);
            end else begin
                chk("sv_later", o_sv, 0);
            end
            k     = c / 2;
            e_da  = (lanes == 2) ? cur[wd-1-2*k] : cur[wd-1-k];
            e_db  = (lanes == 2) ? cur[wd-2-2*k] : 1'b0;
            e_dco = ((c % 4) == 1) || ((c % 4) == 2);
            chk($sformatf("da_c%0d", c), o_da, e_da);
            chk($sformatf("db_c%0d", c), o_db, e_db);
            chk($sformatf("dco_c%0d", c), o_dco, e_dco);
            chk("out_busy", o_busy, 1);
            chk("overrun", o_ov, (ov_at >= 0 && c == ov_at + 1));
            if (c == rst_at) begin
                #1 reset = 1'b0;
                #1;
                chk("rst_dco", o_dco, 0);
                chk("rst_da", o_da, 0);
                chk("rst_db", o_db, 0);
                chk("rst_busy", o_busy, 0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (c == ov_at) begin
                if (sel) cnv_b = 1'b1; else cnv_a = 1'b1;
            end
            if (c == ov_at + 1) begin
                cnv_a = 1'b0; cnv_b = 1'b0;
            end
            @(negedge clk);
        end
        chk("end_busy", o_busy, 0);
        chk("end_dco", o_dco, 0);
        chk("end_da", o_da, 0);
        chk("end_hold", o_so, cur);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b0; reset = 1'b0; cnv_a = 1'b0; cnv_b = 1'b0;
        mode_a = 2'd2; wr_en_a = 1'b0; wr_addr_a = 1'b0; wr_data_a = 18'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", o_busy, 0);
        chk("rst_dco0", o_dco, 0);
        chk("rst_da0", o_da, 0);
        chk("rst_db0", o_db, 0);
        chk("rst_ov0", o_ov, 0);
        chk("rst_sv0", o_sv, 0);
        chk("rst_so0", o_so, 0);
        reset = 1'b1;

        // Fixed test word, dual lane
        run_burst(18'h28FFC, -1, -1, 1'b0, 18'd0);

        // Pattern RAM with wrap
        @(negedge clk);
        mode_a = 2'd0; wr_en_a = 1'b1; wr_addr_a = 1'b0; wr_data_a = 18'h3FFFF;
        @(negedge clk);
        wr_addr_a = 1'b1; wr_data_a = 18'h15555;
        @(negedge clk);
        wr_en_a = 1'b0;
        run_burst(18'h3FFFF, -1, -1, 1'b0, 18'd0);
        run_burst(18'h15555, -1, -1, 1'b0, 18'd0);
        run_burst(18'h3FFFF, -1, -1, 1'b0, 18'd0);

        // Rejected edge mid-burst must not advance the RAM index
        run_burst(18'h15555, 5, -1, 1'b0, 18'd0);
        run_burst(18'h3FFFF, -1, -1, 1'b0, 18'd0);

        // Reset abort at OUTPUT cycle 7, then a clean burst
        mode_a = 2'd2;
        run_burst(18'h28FFC, -1, 7, 1'b0, 18'd0);
        run_burst(18'h28FFC, -1, -1, 1'b0, 18'd0);

        // Same-cycle write to the latched entry: old word goes out, new one later
        mode_a = 2'd0;
        run_burst(18'h3FFFF, -1, -1, 1'b1, 18'h0AAAA);
        run_burst(18'h15555, -1, -1, 1'b0, 18'd0);
        run_burst(18'h0AAAA, -1, -1, 1'b0, 18'd0);

        // 4-bit single lane ramp, zero latency, wraps after 15
        sel = 1'b1;
        for (int i = 0; i < 18; i++) begin
            run_burst(18'(i % 16), -1, -1, 1'b0, 18'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
